lsu: RTL
========

# lsu

Load/store unit for the RV32I core. It takes a memory instruction from the execute stage: the effective address from the ALU, rs2 store data, and the decoder's `mem_wen` and `byte_mask` (func3 width code). It runs one request/grant/response transaction on the data-memory bus and returns a sign- or zero-extended load value to the writeback mux (MEM_WB path). It stalls the pipeline with `busy` until the access completes.

## Interface
- `TIMEOUT_CYCLES`, 255: bus wait limit in cycles; used only when `LSU_TIMEOUT_EN` is defined.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: memory instruction present; held by the pipeline until `done`.
- `mem_wen` in 1: 1 = store, 0 = load.
- `byte_mask` in 3: func3 width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` in 32: effective byte address.
- `wdata` in 32: store data (rs2).
- `busy` out 1: stall request to the pipeline.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result, valid while `done` is high.
- `misaligned` out 1: qualifies `done`; access was rejected for misalignment.
- `bus_err` out 1: qualifies `done`; access timed out.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_be` out 4, `dmem_wdata` out 32: bus request.
- `dmem_gnt` in 1, `dmem_rvalid` in 1, `dmem_rdata` in 32: bus grant and response.

## Operation
- **States:** IDLE, REQ, RESP, DONE.
- **IDLE:**
  - With `req_valid` high, latch `addr`, `wdata`, `mem_wen` and `byte_mask`.
  - If aligned, go to REQ.
  - If misaligned, go to DONE with `misaligned` set and no bus activity.
- **Width rules:**
  - Codes 011, 110 and 111 are treated as W.
  - For stores, `byte_mask[2]` is ignored.
- **Misalignment:** H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
- **REQ:**
  - Drive `dmem_req`=1 with `dmem_we` = latched `mem_wen`, `dmem_addr` = {addr[31:2],2'b00}, and `dmem_be` / `dmem_wdata` per the rules below.
  - Outputs are held stable until `dmem_gnt`.
  - On grant, a store goes to DONE and a load goes to RESP.
- **Byte enables:**
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- **Store data:**
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- **RESP:**
  - Wait for `dmem_rvalid`.
  - Register `rdata` = (`dmem_rdata` >> 8*addr[1:0]), then extend: sign-extend from bit 7 (B) or bit 15 (H); zero-extend for BU/HU; W unchanged.
  - Go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then unconditionally return to IDLE. The still-asserted `req_valid` is not re-accepted.
- **Stall:** `busy` = `req_valid` & ~`done` (combinational).
- **Qualifier timing:** `misaligned` and `bus_err` are valid only in the DONE cycle; 0 otherwise.
- **`rdata` for non-load completions:** 0 for stores, misaligned accesses and timeouts.
- **Ignored inputs:** `dmem_gnt` outside REQ and `dmem_rvalid` outside RESP.

## Timing
- **Reset:**
  - State IDLE.
  - `done`, `misaligned`, `bus_err`, `rdata`, `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` are all 0 in the cycle after `rst` is sampled.
  - Reset mid-transaction abandons the access; a late `rvalid` is ignored.
- **Store:** `req_valid` at cycle 0 → `dmem_req` at cycle 1 → `gnt` at cycle g ≥ 1 → `done` at g+1. Minimum latency is 2 cycles.
- **Load:** `gnt` at g → `rvalid` at r ≥ g+1 → `done` and `rdata` at r+1. Minimum latency is 3 cycles.
- **Misaligned access:** `done` and `misaligned` at cycle 1; `dmem_req` never asserts.
- **Back-to-back accesses:** the next instruction's `req_valid` is accepted at cycle DONE+1.
- **Output registration:** all bus outputs are registered.

## Configuration
- **`LSU_TIMEOUT_EN` defined:**
  - A counter sized $clog2(TIMEOUT_CYCLES+1) clears on entry to REQ and increments every cycle in REQ or RESP.
  - On reaching `TIMEOUT_CYCLES`, the unit goes to DONE with `bus_err`=1 and drops `dmem_req` the next cycle.
  - A grant or response arriving in the same cycle as the terminal count takes priority over the timeout.
- **`LSU_TIMEOUT_EN` undefined:**
  - No counter is built; `bus_err` is tied to 0.
  - The unit waits indefinitely in REQ and RESP.

## Test plan
- LW at 0x0000_1000, `gnt` 2 cycles after `dmem_req`, `rvalid` 1 cycle later with 0xDEAD_BEEF → `rdata`=0xDEAD_BEEF, `done` for one cycle, `busy` high until then.
- LB and LBU at 0x0000_1003 with `dmem_rdata`=0x80AB_CDEF → LB gives 0xFFFF_FF80, LBU gives 0x0000_0080; `dmem_addr`=0x0000_1000.
- SH at 0x0000_0102 with `wdata`=0x1234_ABCD → `dmem_be`=4'b1100, `dmem_wdata`=0xABCD_ABCD, `dmem_we`=1; `done` the cycle after `gnt`.
- LW at 0x0000_0101 → `done` and `misaligned` at cycle 1, `dmem_req` stays 0; a following aligned SW is accepted normally.
- `LSU_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4 and `gnt` held low → `bus_err` and `done` after 4 REQ cycles, then `dmem_req`=0.
- `rst` asserted in RESP, then `rvalid` after reset → all outputs 0, no `done`, unit idle and accepts the next request.

Source files
------------

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: one req/gnt/rvalid bus transaction per memory instruction.
// Define LSU_TIMEOUT_EN to build the bus wait timeout (TIMEOUT_CYCLES); otherwise bus_err is always 0.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_wen,
  input  logic [2:0]  byte_mask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state;
  logic [1:0]  addr_lo;
  logic [2:0]  mask_q;
  logic        wen_q;

  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        misalign_next;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic        tmo;

  // Width is decided by the low two bits alone: 011/110/111 fall into W, and bit 2 only selects zero-extension.
  always_comb begin
    be_next       = 4'b1111;
    wdata_next    = wdata;
    misalign_next = |addr[1:0];
    case (byte_mask[1:0])
      2'b00: begin
        be_next       = 4'b0001 << addr[1:0];
        wdata_next    = {4{wdata[7:0]}};
        misalign_next = 1'b0;
      end
      2'b01: begin
        be_next       = 4'b0011 << {addr[1], 1'b0};
        wdata_next    = {2{wdata[15:0]}};
        misalign_next = addr[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted  = dmem_rdata >> {addr_lo, 3'b000};
    load_val = shifted;
    case (mask_q[1:0])
      2'b00:   load_val = mask_q[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = mask_q[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;

  // Budget is shared by REQ and RESP; >= keeps a grant taken at the terminal count from wrapping.
  assign tmo = (tcnt >= CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      tcnt <= '0;
    end else if ((state == REQ || state == RESP) && !tmo) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo = 1'b0;
`endif

  assign busy = req_valid & ~done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_lo    <= '0;
      mask_q     <= '0;
      wen_q      <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_lo <= addr[1:0];
            mask_q  <= byte_mask;
            wen_q   <= mem_wen;
            if (misalign_next) begin
              state      <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_wen;
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_be    <= be_next;
              dmem_wdata <= wdata_next;
            end
          end
        end
        REQ: begin
          if (dmem_gnt || tmo) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            if (dmem_gnt && !wen_q) begin
              state <= RESP;
            end else begin
              state   <= DONE;
              done    <= 1'b1;
              bus_err <= ~dmem_gnt;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            state <= DONE;
            done  <= 1'b1;
            rdata <= load_val;
          end else if (tmo) begin
            state   <= DONE;
            done    <= 1'b1;
            bus_err <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b0;
          rdata      <= '0;
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
